mtm_alu_ctrl: RTL and testbench
===============================

MTM_ALU_CTRL -- requirements
Module: mtm_alu_ctrl

Interface
REQ-001 Parameter ALU_TIMEOUT, default 16: max cycles to wait for alu_done before aborting.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  one-cycle pulse; in_a/in_b/in_ctl hold a complete deserialized frame.
REQ-005 in_a, in_b  input  32 each  operands A and B.
REQ-006 in_ctl  input  8  frame CTL byte; bit7=1 means a deserializer error code; op = in_ctl[6:4] otherwise.
REQ-007 alu_start  output  1  one-cycle pulse launching the ALU core.
REQ-008 alu_op  output  3  operation code to the ALU core.
REQ-009 alu_a, alu_b  output  32 each  registered operands to the ALU core.
REQ-010 alu_done  input  1  one-cycle pulse; alu_c/alu_flags valid.
REQ-011 alu_c  input  32  ALU result.
REQ-012 alu_flags  input  4  {carry, overflow, zero, negative}.
REQ-013 tx_valid  output  1  response ready for the serializer.
REQ-014 tx_ready  input  1  serializer accepts the response when high together with tx_valid.
REQ-015 tx_c  output  32  result word; 0 when tx_err=1.
REQ-016 tx_ctl  output  8  response CTL byte.
REQ-017 tx_err  output  1  1 = single-byte error response (tx_ctl only).
REQ-018 busy  output  1  high whenever state != IDLE.
REQ-019 drop_cnt  output  8  frames dropped because in_valid arrived while busy; saturates at 255.

Function
REQ-020 States: IDLE, DECODE, EXEC, WAIT_ALU, CRC, SEND.
REQ-021 IDLE: in_valid=1 -> register in_a/in_b/in_ctl, go to DECODE.
REQ-022 DECODE: ctl[7]=1 -> SEND with error response; op in {000 AND, 001 OR, 100 ADD, 101 SUB} -> EXEC; any other op -> SEND with ERR_OP.
REQ-023 EXEC: alu_start=1 for exactly one cycle with alu_a/alu_b/alu_op stable; go to WAIT_ALU, clear the timeout counter.
REQ-024 WAIT_ALU: alu_done=1 -> capture alu_c/alu_flags, go to CRC; counter reaching ALU_TIMEOUT without alu_done -> SEND with ERR_OP.
REQ-025 CRC: tx_ctl = {1'b0, flags[3:0], crc3}, where crc3 is CRC-3 (poly x^3+x+1, init 000) over the 37-bit vector {C, 1'b0, flags}, MSB first; tx_c = C; go to SEND.
REQ-026 Error byte = {1'b1, ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP, P}, where P is the even parity of bits 7:1.
REQ-027 An incoming error ctl (0xC9 data, 0xA5 CRC) is forwarded unchanged; ERR_OP produces 0x93.
REQ-028 SEND: tx_valid=1 with tx_c/tx_ctl/tx_err held stable until tx_ready=1; the handshake cycle returns to IDLE and deasserts tx_valid next cycle.
REQ-029 Latency of a valid op: in_valid at cycle 0 -> alu_start at cycle 2; alu_done at cycle N -> tx_valid at cycle N+2.
REQ-030 Error path: in_valid at cycle 0 -> tx_valid at cycle 2.
REQ-031 in_valid while busy=1 is ignored and increments drop_cnt; no effect on the frame in flight.
REQ-032 in_valid in the same cycle as the SEND handshake is dropped; it is accepted only in IDLE.
REQ-033 alu_done outside WAIT_ALU is ignored.
REQ-034 tx_ready outside SEND is ignored.

Reset
REQ-035 rst=0 at a clock edge forces IDLE, including mid-frame; any pending response is discarded.
REQ-036 Reset values: alu_start=0, alu_op=0, alu_a=0, alu_b=0, tx_valid=0, tx_c=0, tx_ctl=0xFF, tx_err=0, busy=0, drop_cnt=0.

Structure
REQ-037 A shared package mtm_alu_pkg holds: op codes, state encoding, error bytes 0xC9/0xA5/0x93, CRC-3 polynomial and the idle CTL value 0xFF.
REQ-038 CRC-3 sits in a combinational sub-module mtm_alu_crc3 (37-bit data in, 3-bit CRC out).

Verification
REQ-039 ADD test: A=1, B=2, ctl op=100 -> alu_op=100 at cycle 2; ALU returns C=3, flags 0000 -> tx_c=3, tx_ctl[7:3]=00000, tx_ctl[2:0]=model CRC3, tx_err=0.
REQ-040 Forwarded error: in_ctl=0xC9 -> no alu_start; tx_valid at cycle 2 with tx_err=1, tx_ctl=0xC9, tx_c=0.
REQ-041 Bad op and timeout: op=011 -> tx_ctl=0x93; alu_done withheld for 16 cycles -> tx_ctl=0x93.
REQ-042 Backpressure and drops: tx_ready held low 10 cycles -> outputs stable; 3 extra in_valid pulses during this time -> drop_cnt=3, exactly one response.
REQ-043 Reset: rst=0 in WAIT_ALU -> next cycle busy=0, tx_valid=0, tx_ctl=0xFF; a later frame completes normally.
REQ-044 AND test: A=0xF0F0F0F0, B=0x0F0F0F0F, op=000, ALU flags 0010 -> tx_c=0, tx_ctl[7:3]=00010, tx_ctl[2:0]=model CRC3.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared constants and types for the ALU frame controller
//
// Purpose: op codes, controller state encoding, response CTL bytes,
//          CRC-3 polynomial and the captured ALU result record.
// Ports:   none (package).

package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Error bytes: {1, data, crc, op, data, crc, op, even parity of bits 7:1}
  localparam logic [7:0] ERR_DATA_CTL = 8'hC9;
  localparam logic [7:0] ERR_CRC_CTL  = 8'hA5;
  localparam logic [7:0] ERR_OP_CTL   = 8'h93;

  localparam logic [7:0] IDLE_CTL = 8'hFF;

  // x^3 + x + 1, the x^3 term is implicit
  localparam logic [2:0] CRC3_POLY = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_CRC,
    S_SEND
  } state_t;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  flags;  // {carry, overflow, zero, negative}
  } alu_res_t;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_ctrl_if.sv
// rtl/mtm_alu_ctrl_if.sv - frame, ALU-core and serializer signals of the controller
//
// Purpose: bundles the deserializer input, ALU core handshake, serializer
//          response and status signals.
// Modports:
//   slave  - the controller (mtm_alu_ctrl)
//   master - the environment around it (deserializer, ALU core, serializer)

interface mtm_alu_ctrl_if;

  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [7:0]  in_ctl;

  logic        alu_start;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_c;
  logic [3:0]  alu_flags;

  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_c;
  logic [7:0]  tx_ctl;
  logic        tx_err;

  logic        busy;
  logic [7:0]  drop_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_ctl, alu_done, alu_c, alu_flags, tx_ready,
    output alu_start, alu_op, alu_a, alu_b, tx_valid, tx_c, tx_ctl, tx_err,
           busy, drop_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_ctl, alu_done, alu_c, alu_flags, tx_ready,
    input  alu_start, alu_op, alu_a, alu_b, tx_valid, tx_c, tx_ctl, tx_err,
           busy, drop_cnt
  );

endinterface

// File: rtl/mtm_alu_crc3.sv
// rtl/mtm_alu_crc3.sv - combinational CRC-3 over a 37-bit word
//
// Purpose: CRC-3, poly x^3+x+1, init 000, MSB first, no final xor.
// Ports:
//   data - 37-bit input vector ({C, 1'b0, flags} in the controller)
//   crc  - 3-bit remainder

module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [36:0] data,
  output logic [2:0]  crc
);

  logic [2:0] acc;
  logic       fb;

  // Bit-serial LFSR unrolled over all 37 bits
  always_comb begin
    acc = 3'b000;
    fb  = 1'b0;
    for (int i = 36; i >= 0; i--) begin
      fb  = acc[2] ^ data[i];
      acc = {acc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    crc = acc;
  end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// rtl/mtm_alu_ctrl.sv - frame controller between deserializer, ALU core and serializer
//
// Purpose: accepts one decoded frame at a time, launches the ALU core for
//          AND/OR/ADD/SUB, waits for its result (with timeout), builds the
//          response CTL byte (flags + CRC-3) or an error byte, and holds the
//          response until the serializer takes it.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous, active-low reset
//   bus - mtm_alu_ctrl_if.slave: in_* frame, alu_* core handshake,
//         tx_* response, busy / drop_cnt status

module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mtm_alu_ctrl_if.slave  bus
);

  // Counter only ever reaches ALU_TIMEOUT, so this width always fits
  localparam int CW = $clog2(ALU_TIMEOUT + 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  ctl_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [CW-1:0] tmo_cnt;
  alu_res_t    res_q;
  logic [2:0]  crc3;
  logic [31:0] tx_c_q;
  logic [7:0]  tx_ctl_q;
  logic        tx_err_q;
  logic [7:0]  drop_q;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == CW'(ALU_TIMEOUT - 1));

  mtm_alu_crc3 u_crc3 (
    .data ({res_q.c, 1'b0, res_q.flags}),
    .crc  (crc3)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.in_valid) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = (!ctl_q[7] && is_valid_op(ctl_q[6:4])) ? S_EXEC : S_SEND;
      S_EXEC:     state_nxt = S_WAIT_ALU;
      S_WAIT_ALU: if (bus.alu_done) state_nxt = S_CRC;
                  else if (tmo_hit) state_nxt = S_SEND;
      S_CRC:      state_nxt = S_SEND;
      S_SEND:     if (bus.tx_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_start = (state == S_EXEC);
    bus.tx_valid  = (state == S_SEND);
    bus.busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q    <= 8'h00;
      op_q     <= 3'b000;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      tmo_cnt  <= '0;
      res_q    <= '0;
      tx_c_q   <= 32'h0;
      tx_ctl_q <= IDLE_CTL;
      tx_err_q <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      // Operands are latched here so they are stable through EXEC
      if (state == S_IDLE && bus.in_valid) begin
        ctl_q <= bus.in_ctl;
        op_q  <= bus.in_ctl[6:4];
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
      end

      if (state == S_EXEC) tmo_cnt <= '0;
      else if (state == S_WAIT_ALU && !bus.alu_done) tmo_cnt <= tmo_cnt + CW'(1);

      if (state == S_WAIT_ALU && bus.alu_done) res_q <= '{c: bus.alu_c, flags: bus.alu_flags};

      case (state)
        S_DECODE: begin
          if (ctl_q[7]) begin
            // Deserializer error code goes out untouched
            tx_c_q   <= 32'h0;
            tx_ctl_q <= ctl_q;
            tx_err_q <= 1'b1;
          end else if (!is_valid_op(ctl_q[6:4])) begin
            tx_c_q   <= 32'h0;
            tx_ctl_q <= ERR_OP_CTL;
            tx_err_q <= 1'b1;
          end
        end
        S_WAIT_ALU: begin
          if (!bus.alu_done && tmo_hit) begin
            tx_c_q   <= 32'h0;
            tx_ctl_q <= ERR_OP_CTL;
            tx_err_q <= 1'b1;
          end
        end
        S_CRC: begin
          tx_c_q   <= res_q.c;
          tx_ctl_q <= {1'b0, res_q.flags, crc3};
          tx_err_q <= 1'b0;
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            tx_c_q   <= 32'h0;
            tx_ctl_q <= IDLE_CTL;
            tx_err_q <= 1'b0;
          end
        end
        default: ;
      endcase

      // Anything outside IDLE, including the SEND handshake cycle, is a drop
      if (state != S_IDLE && bus.in_valid && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.alu_op   = op_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.tx_c     = tx_c_q;
  assign bus.tx_ctl   = tx_ctl_q;
  assign bus.tx_err   = tx_err_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb/tb_mtm_alu_ctrl.sv - directed self-checking bench for mtm_alu_ctrl

module tb_mtm_alu_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mtm_alu_ctrl_if bus ();

  mtm_alu_ctrl #(.ALU_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle in_valid pulse; returns in cycle 1
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ctl   = ctl;
    tick;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_tx(input int max, output int n, output bit ok);
    n = 0;
    while (!bus.tx_valid && n < max) begin
      tick;
      n++;
    end
    ok = bus.tx_valid;
  endtask

  task automatic handshake;
    bus.tx_ready = 1'b1;
    tick;
    bus.tx_ready = 1'b0;
  endtask

  // Full valid-op frame with an ALU reply right after alu_start
  task automatic run_to_send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                             input logic [31:0] c, input logic [3:0] f, output bit ok);
    int n;
    ok = 1'b0;
    launch(a, b, ctl);
    for (int i = 0; i < 8 && !bus.alu_start; i++) tick;
    if (bus.alu_start) begin
      tick;
      bus.alu_done  = 1'b1;
      bus.alu_c     = c;
      bus.alu_flags = f;
      tick;
      bus.alu_done  = 1'b0;
      wait_tx(20, n, ok);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    tests++; if (bus.alu_start !== 1'b0) begin fails++; $display("FAIL rst_alu_start got=%b exp=0", bus.alu_start); end
    tests++; if (bus.alu_op !== 3'b000) begin fails++; $display("FAIL rst_alu_op got=%b exp=000", bus.alu_op); end
    tests++; if ({bus.alu_a, bus.alu_b} !== 64'h0) begin fails++; $display("FAIL rst_alu_ab got=%h exp=0", {bus.alu_a, bus.alu_b}); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid got=%b exp=0", bus.tx_valid); end
    tests++; if (bus.tx_c !== 32'h0) begin fails++; $display("FAIL rst_tx_c got=%h exp=0", bus.tx_c); end
    tests++; if (bus.tx_ctl !== 8'hFF) begin fails++; $display("FAIL rst_tx_ctl got=%h exp=ff", bus.tx_ctl); end
    tests++; if (bus.tx_err !== 1'b0) begin fails++; $display("FAIL rst_tx_err got=%b exp=0", bus.tx_err); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.drop_cnt !== 8'h00) begin fails++; $display("FAIL rst_drop_cnt got=%h exp=0", bus.drop_cnt); end
    rst = 1'b1;
    tick;
  endtask

  // Exact cycle latencies; CRC3 of {3, 0, 0000} is 110 -> ctl 0x06
  task automatic test_add;
    launch(32'd1, 32'd2, 8'h40);
    tests++; if (bus.busy !== 1'b1 || bus.alu_start !== 1'b0) begin fails++; $display("FAIL add_c1 got busy=%b start=%b exp busy=1 start=0", bus.busy, bus.alu_start); end
    tick;
    tests++; if (bus.alu_start !== 1'b1) begin fails++; $display("FAIL add_start got=%b exp=1", bus.alu_start); end
    tests++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'b100, 32'd1, 32'd2}) begin fails++; $display("FAIL add_operands got op=%b a=%h b=%h exp op=100 a=1 b=2", bus.alu_op, bus.alu_a, bus.alu_b); end
    tick;
    tests++; if (bus.alu_start !== 1'b0) begin fails++; $display("FAIL add_start_pulse got=%b exp=0", bus.alu_start); end
    bus.alu_done  = 1'b1;
    bus.alu_c     = 32'd3;
    bus.alu_flags = 4'b0000;
    tick;
    bus.alu_done  = 1'b0;
    bus.alu_c     = 32'hDEAD_BEEF;
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL add_tx_early got=%b exp=0", bus.tx_valid); end
    tick;
    tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL add_tx_valid got=%b exp=1", bus.tx_valid); end
    tests++; if (bus.tx_c !== 32'd3) begin fails++; $display("FAIL add_tx_c got=%h exp=3", bus.tx_c); end
    tests++; if (bus.tx_ctl !== 8'h06) begin fails++; $display("FAIL add_tx_ctl got=%h exp=06", bus.tx_ctl); end
    tests++; if (bus.tx_err !== 1'b0) begin fails++; $display("FAIL add_tx_err got=%b exp=0", bus.tx_err); end
    handshake;
    tests++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL add_done got valid=%b busy=%b exp 0 0", bus.tx_valid, bus.busy); end
  endtask

  // CRC3 of {0, 0, 0010} is x^4 mod g = 110 -> ctl 0x16
  task automatic test_and;
    bit ok;
    run_to_send(32'hF0F0_F0F0, 32'h0F0F_0F0F, 8'h00, 32'h0, 4'b0010, ok);
    tests++; if (!ok) begin fails++; $display("FAIL and_tx_timeout got=no tx_valid exp=tx_valid"); end
    tests++; if (bus.tx_c !== 32'h0) begin fails++; $display("FAIL and_tx_c got=%h exp=0", bus.tx_c); end
    tests++; if (bus.tx_ctl !== 8'h16) begin fails++; $display("FAIL and_tx_ctl got=%h exp=16", bus.tx_ctl); end
    tests++; if (bus.tx_err !== 1'b0) begin fails++; $display("FAIL and_tx_err got=%b exp=0", bus.tx_err); end
    handshake;
  endtask

  task automatic test_error_fwd;
    logic [7:0] codes [2];
    codes[0] = 8'hC9;
    codes[1] = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      launch(32'h1234_5678, 32'h9ABC_DEF0, codes[k]);
      tests++; if (bus.alu_start !== 1'b0 || bus.tx_valid !== 1'b0) begin fails++; $display("FAIL err_fwd_c1 got start=%b valid=%b exp 0 0", bus.alu_start, bus.tx_valid); end
      tick;
      tests++; if (bus.alu_start !== 1'b0) begin fails++; $display("FAIL err_fwd_start got=%b exp=0", bus.alu_start); end
      tests++; if ({bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c} !== {1'b1, 1'b1, codes[k], 32'h0}) begin fails++; $display("FAIL err_fwd_resp got valid=%b err=%b ctl=%h c=%h exp 1 1 %h 0", bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c, codes[k]); end
      handshake;
    end
  endtask

  task automatic test_bad_op;
    logic [7:0] ctls [3];
    ctls[0] = 8'h30;
    ctls[1] = 8'h60;
    ctls[2] = 8'h70;
    for (int k = 0; k < 3; k++) begin
      launch(32'd7, 32'd9, ctls[k]);
      tick;
      tests++; if ({bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c, bus.alu_start} !== {1'b1, 1'b1, 8'h93, 32'h0, 1'b0}) begin fails++; $display("FAIL bad_op_resp ctl_in=%h got valid=%b err=%b ctl=%h c=%h start=%b exp 1 1 93 0 0", ctls[k], bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c, bus.alu_start); end
      handshake;
    end
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    launch(32'd5, 32'd3, 8'h50);
    tick;
    tests++; if (bus.alu_start !== 1'b1 || bus.alu_op !== 3'b101) begin fails++; $display("FAIL tmo_start got start=%b op=%b exp 1 101", bus.alu_start, bus.alu_op); end
    wait_tx(40, n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL tmo_no_resp got=no tx_valid exp=tx_valid"); end
    tests++; if (n <= 16) begin fails++; $display("FAIL tmo_early got=%0d cycles exp=>16", n); end
    tests++; if ({bus.tx_err, bus.tx_ctl, bus.tx_c} !== {1'b1, 8'h93, 32'h0}) begin fails++; $display("FAIL tmo_resp got err=%b ctl=%h c=%h exp 1 93 0", bus.tx_err, bus.tx_ctl, bus.tx_c); end
    handshake;
    bus.alu_done = 1'b1;
    bus.alu_c    = 32'h5;
    tick;
    bus.alu_done = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin fails++; $display("FAIL tmo_late_done got busy=%b valid=%b exp 0 0", bus.busy, bus.tx_valid); end
  endtask

  // OR: CRC3 of {0x0000FFFF, 0, 1000} = 110 ^ 101 = 011 -> ctl 0x43
  task automatic test_back_to_back;
    bit ok;
    bit seen;
    run_to_send(32'h0000_00FF, 32'h0000_FF00, 8'h10, 32'h0000_FFFF, 4'b1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_tx_timeout got=no tx_valid exp=tx_valid"); end
    for (int i = 0; i < 10; i++) begin
      tests++; if ({bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c} !== {1'b1, 1'b0, 8'h43, 32'h0000_FFFF}) begin fails++; $display("FAIL bp_hold cyc=%0d got valid=%b err=%b ctl=%h c=%h exp 1 0 43 0000ffff", i, bus.tx_valid, bus.tx_err, bus.tx_ctl, bus.tx_c); end
      bus.in_valid = (i == 2 || i == 4 || i == 6);
      bus.in_a     = 32'hAAAA_0000 + 32'(i);
      bus.in_ctl   = 8'h40;
      tick;
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.drop_cnt !== 8'd3) begin fails++; $display("FAIL bp_drop_cnt got=%0d exp=3", bus.drop_cnt); end
    bus.in_valid = 1'b1;
    handshake;
    bus.in_valid = 1'b0;
    tests++; if (bus.drop_cnt !== 8'd4 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL bp_hs_drop got drop=%0d valid=%b busy=%b exp 4 0 0", bus.drop_cnt, bus.tx_valid, bus.busy); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen = seen | bus.busy | bus.tx_valid;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL bp_extra_resp got=activity exp=idle"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    launch(32'd1, 32'd2, 8'h40);
    tick;
    tick;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_pre got=%b exp=1", bus.busy); end
    rst = 1'b0;
    tick;
    tests++; if ({bus.busy, bus.tx_valid, bus.tx_ctl, bus.drop_cnt} !== {1'b0, 1'b0, 8'hFF, 8'h00}) begin fails++; $display("FAIL rmid_state got busy=%b valid=%b ctl=%h drop=%0d exp 0 0 ff 0", bus.busy, bus.tx_valid, bus.tx_ctl, bus.drop_cnt); end
    rst = 1'b1;
    bus.alu_done = 1'b1;
    bus.alu_c    = 32'd3;
    tick;
    bus.alu_done = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rmid_stale_done got busy=%b valid=%b exp 0 0", bus.busy, bus.tx_valid); end
    run_to_send(32'd1, 32'd2, 8'h40, 32'd3, 4'b0000, ok);
    tests++; if (!ok || bus.tx_c !== 32'd3 || bus.tx_ctl !== 8'h06 || bus.tx_err !== 1'b0) begin fails++; $display("FAIL rmid_after got ok=%b c=%h ctl=%h err=%b exp 1 3 06 0", ok, bus.tx_c, bus.tx_ctl, bus.tx_err); end
    handshake;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.in_ctl    = 8'h00;
    bus.alu_done  = 1'b0;
    bus.alu_c     = 32'h0;
    bus.alu_flags = 4'h0;
    bus.tx_ready  = 1'b0;
    test_reset;
    test_add;
    test_and;
    test_error_fwd;
    test_bad_op;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
